// File: rtl/bcd_updown_counter_if.sv
// Load/control inputs and count/status outputs of bcd_updown_counter.
// master drives the controls and samples the status; slave is the counter side.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 2
);
  logic                  load_n;
  logic                  enable;
  logic                  updown;
  logic [4*DIGITS-1:0]   load_data;
  logic [4*DIGITS-1:0]   count;
  logic                  carry_out;
  logic                  borrow_out;
  logic                  load_err;
  logic                  at_max;
  logic                  at_zero;

  modport master (
    output load_n, enable, updown, load_data,
    input  count, carry_out, borrow_out, load_err, at_max, at_zero
  );

  modport slave (
    input  load_n, enable, updown, load_data,
    output count, carry_out, borrow_out, load_err, at_max, at_zero
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with clamping parallel load; wraps or saturates at the limits.
// Count and pulse flags update one edge after the inputs; no backpressure, at_max/at_zero follow count.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                clock,
  input  logic                clear_n,
  bcd_updown_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      count_q;
  logic [W-1:0]      load_fixed;
  logic [W-1:0]      count_inc;
  logic [W-1:0]      count_dec;
  logic [DIGITS-1:0] digit_bad;
  logic [DIGITS:0]   up_en;
  logic [DIGITS:0]   dn_en;
  logic              at_max_w;
  logic              at_zero_w;
  logic              carry_q;
  logic              borrow_q;
  logic              load_err_q;

  assign up_en[0] = 1'b1;
  assign dn_en[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] cur;
    logic [3:0] ld;

    assign cur          = count_q[4*k +: 4];
    assign ld           = bus.load_data[4*k +: 4];
    assign digit_bad[k] = (ld > 4'd9);
    assign load_fixed[4*k +: 4] = digit_bad[k] ? 4'd9 : ld;

    // A digit steps only when every lower digit is rolling over this edge.
    assign up_en[k+1] = up_en[k] & (cur == 4'd9);
    assign dn_en[k+1] = dn_en[k] & (cur == 4'd0);

    assign count_inc[4*k +: 4] = !up_en[k]      ? cur :
                                 (cur == 4'd9)  ? 4'd0 : cur + 4'd1;
    assign count_dec[4*k +: 4] = !dn_en[k]      ? cur :
                                 (cur == 4'd0)  ? 4'd9 : cur - 4'd1;
  end

  // The full-cascade terms double as the limit detectors.
  assign at_max_w  = up_en[DIGITS];
  assign at_zero_w = dn_en[DIGITS];

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      if (!bus.load_n) begin
        count_q    <= load_fixed;
        load_err_q <= |digit_bad;
      end else if (bus.enable) begin
        if (bus.updown) begin
          carry_q <= at_max_w;
          if (!at_max_w || (WRAP != 0)) begin
            count_q <= count_inc;
          end
        end else begin
          borrow_q <= at_zero_w;
          if (!at_zero_w || (WRAP != 0)) begin
            count_q <= count_dec;
          end
        end
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.carry_out  = carry_q;
  assign bus.borrow_out = borrow_q;
  assign bus.load_err   = load_err_q;
  assign bus.at_max     = at_max_w;
  assign bus.at_zero    = at_zero_w;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating instance driven in lockstep,
// checked with directed vectors and randomized stimulus against an integer reference model.
module tb_bcd_updown_counter;
  localparam int MAXV = 99;

  typedef struct {
    logic [3:0] ctl;   // {clear_n, load_n, enable, updown}
    logic [7:0] ld;
    logic [7:0] cnt;
    logic [2:0] flg;   // {carry, borrow, load_err}
  } vec_t;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  bcd_updown_counter_if #(.DIGITS(2)) if_w ();
  bcd_updown_counter_if #(.DIGITS(2)) if_s ();

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_wrap (.clock(clock), .clear_n(clear_n), .bus(if_w));
  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_sat  (.clock(clock), .clear_n(clear_n), .bus(if_s));

  int n_chk  = 0;
  int n_pass = 0;
  int mv_w = 0, mv_s = 0;
  bit mc_w, mb_w, me_w, mc_s, mb_s, me_s;
  vec_t tbl[30];

  function automatic vec_t mk(input logic [3:0] ctl, input logic [7:0] ld,
                              input logic [7:0] cnt, input logic [2:0] flg);
    vec_t v;
    v.ctl = ctl; v.ld = ld; v.cnt = cnt; v.flg = flg;
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference: the count is an integer 0..99; BCD only appears at the boundary.
  function automatic void ref_step(input bit wrap, input logic clr, input logic ld_n,
                                   input logic en, input logic ud, input logic [7:0] ld,
                                   inout int v, output bit c, output bit b, output bit e);
    int hi, lo;
    c = 1'b0; b = 1'b0; e = 1'b0;
    if (!clr) begin
      v = 0;
    end else if (!ld_n) begin
      hi = int'(ld[7:4]);
      lo = int'(ld[3:0]);
      e  = (hi > 9) || (lo > 9);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      v = hi * 10 + lo;
    end else if (en) begin
      if (ud) begin
        if (v == MAXV) begin c = 1'b1; if (wrap) v = 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin b = 1'b1; if (wrap) v = MAXV; end
        else v = v - 1;
      end
    end
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_dut(input string tag, input bit sat, input logic [7:0] ec,
                           input logic [2:0] flg);
    logic [7:0] cnt;
    logic co, bo, le, am, az;
    if (sat) begin
      cnt = if_s.count; co = if_s.carry_out; bo = if_s.borrow_out;
      le = if_s.load_err; am = if_s.at_max; az = if_s.at_zero;
    end else begin
      cnt = if_w.count; co = if_w.carry_out; bo = if_w.borrow_out;
      le = if_w.load_err; am = if_w.at_max; az = if_w.at_zero;
    end
    check({tag, " count"},      cnt,          ec);
    check({tag, " carry_out"},  {7'd0, co},   {7'd0, flg[2]});
    check({tag, " borrow_out"}, {7'd0, bo},   {7'd0, flg[1]});
    check({tag, " load_err"},   {7'd0, le},   {7'd0, flg[0]});
    check({tag, " at_max"},     {7'd0, am},   {7'd0, ec == 8'h99});
    check({tag, " at_zero"},    {7'd0, az},   {7'd0, ec == 8'h00});
  endtask

  task automatic step(input logic clr, input logic ld_n, input logic en,
                      input logic ud, input logic [7:0] ld);
    clear_n = clr;
    if_w.load_n = ld_n; if_w.enable = en; if_w.updown = ud; if_w.load_data = ld;
    if_s.load_n = ld_n; if_s.enable = en; if_s.updown = ud; if_s.load_data = ld;
    @(posedge clock);
    #1;
    ref_step(1'b1, clr, ld_n, en, ud, ld, mv_w, mc_w, mb_w, me_w);
    ref_step(1'b0, clr, ld_n, en, ud, ld, mv_s, mc_s, mb_s, me_s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] sat_up [4];
    logic [2:0] sat_upf[4];
    logic [2:0] sat_dnf[3];
    logic       clr, ld_n, en, ud;
    logic [7:0] ld;

    // Wrap-mode vectors: each row is applied for one edge, then compared.
    tbl[0]  = mk(4'b0000, 8'h00, 8'h00, 3'b000);
    tbl[1]  = mk(4'b1000, 8'h10, 8'h10, 3'b000);
    tbl[2]  = mk(4'b1110, 8'h00, 8'h09, 3'b000);
    tbl[3]  = mk(4'b1110, 8'h00, 8'h08, 3'b000);
    tbl[4]  = mk(4'b1010, 8'h00, 8'h00, 3'b000);
    tbl[5]  = mk(4'b1110, 8'h00, 8'h99, 3'b010);
    tbl[6]  = mk(4'b1101, 8'h00, 8'h99, 3'b000);
    tbl[7]  = mk(4'b1000, 8'hB4, 8'h94, 3'b001);
    tbl[8]  = mk(4'b1000, 8'h37, 8'h37, 3'b000);
    tbl[9]  = mk(4'b1011, 8'h55, 8'h55, 3'b000);
    tbl[10] = mk(4'b1000, 8'h41, 8'h41, 3'b000);
    tbl[11] = mk(4'b1111, 8'h00, 8'h42, 3'b000);
    tbl[12] = mk(4'b0011, 8'h77, 8'h00, 3'b000);
    tbl[13] = mk(4'b1000, 8'h50, 8'h50, 3'b000);
    tbl[14] = mk(4'b1100, 8'h00, 8'h50, 3'b000);
    tbl[15] = mk(4'b1101, 8'h00, 8'h50, 3'b000);
    tbl[16] = mk(4'b1100, 8'h00, 8'h50, 3'b000);
    tbl[17] = mk(4'b1111, 8'h00, 8'h51, 3'b000);
    tbl[18] = mk(4'b1110, 8'h00, 8'h50, 3'b000);
    tbl[19] = mk(4'b1111, 8'h00, 8'h51, 3'b000);
    tbl[20] = mk(4'b1110, 8'h00, 8'h50, 3'b000);
    tbl[21] = mk(4'b1000, 8'h99, 8'h99, 3'b000);
    tbl[22] = mk(4'b1111, 8'h00, 8'h00, 3'b100);
    tbl[23] = mk(4'b1111, 8'h00, 8'h01, 3'b000);
    tbl[24] = mk(4'b1000, 8'hFF, 8'h99, 3'b001);
    tbl[25] = mk(4'b0111, 8'h00, 8'h00, 3'b000);
    tbl[26] = mk(4'b1000, 8'h9A, 8'h99, 3'b001);
    tbl[27] = mk(4'b1111, 8'h00, 8'h00, 3'b100);
    tbl[28] = mk(4'b1110, 8'h00, 8'h99, 3'b010);
    tbl[29] = mk(4'b1100, 8'h00, 8'h99, 3'b000);

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0], tbl[i].ld);
      check_dut($sformatf("vec%0d", i), 1'b0, tbl[i].cnt, tbl[i].flg);
    end

    // Full up-count sweep through the wrap point.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_dut("sweep reset", 1'b0, 8'h00, 3'b000);
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      check_dut($sformatf("sweep%0d", i), 1'b0, to_bcd(i % 100), {i == 100, 2'b00});
    end

    // Saturating instance: hold at the limits while pulsing.
    sat_up  = '{8'h98, 8'h99, 8'h99, 8'h99};
    sat_upf = '{3'b000, 3'b000, 3'b100, 3'b100};
    sat_dnf = '{3'b000, 3'b010, 3'b010};
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_dut("sat reset", 1'b1, 8'h00, 3'b000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h97);
    check_dut("sat load97", 1'b1, 8'h97, 3'b000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      check_dut($sformatf("sat up%0d", i + 1), 1'b1, sat_up[i], sat_upf[i]);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    check_dut("sat load01", 1'b1, 8'h01, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      check_dut($sformatf("sat dn%0d", i + 1), 1'b1, 8'h00, sat_dnf[i]);
    end

    // Randomized traffic on both instances against the reference model.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom_range(0, 31) != 0);
      ld_n = ($urandom_range(0, 7) != 0);
      en   = ($urandom_range(0, 3) != 0);
      ud   = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 5))
        0:       ld = 8'h99;
        1:       ld = 8'h00;
        2:       ld = 8'h98;
        3:       ld = 8'h01;
        default: ld = 8'($urandom);
      endcase
      step(clr, ld_n, en, ud, ld);
      check_dut($sformatf("rnd%0d wrap", i), 1'b0, to_bcd(mv_w), {mc_w, mb_w, me_w});
      check_dut($sformatf("rnd%0d sat", i),  1'b1, to_bcd(mv_s), {mc_s, mb_s, me_s});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, setting the number of cascaded BCD digits (legal 1..8).
REQ-002 The block SHALL have parameter WRAP, default 1; 1 means wrap at the count limits, 0 means saturate.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 clear_n  input  1  synchronous active-low reset; sampled on the rising edge of clock.
REQ-006 load_n  input  1  active-low synchronous parallel load.
REQ-007 enable  input  1  active-high count enable.
REQ-008 updown  input  1  direction; 1 means count up, 0 means count down.
REQ-009 load_data  input  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
REQ-010 count  output  4*DIGITS  registered BCD count; digit 0 is in bits [3:0].
REQ-011 carry_out  output  1  registered one-cycle pulse on an up-count attempted at the maximum value (all digits 9).
REQ-012 borrow_out  output  1  registered one-cycle pulse on a down-count attempted at zero.
REQ-013 load_err  output  1  registered one-cycle pulse when a load contained a non-BCD digit.
REQ-014 at_max, at_zero  output  1 each  combinational flags: count is all 9s, or count is 0.

Function
REQ-015 Per-edge priority SHALL be: clear_n low, then load_n low, then enable high, then hold.
REQ-016 Load SHALL take effect at the next edge, regardless of enable and updown.
REQ-017 On load, any digit greater than 9 SHALL be clamped to 9, and load_err SHALL be 1 for the next cycle.
REQ-018 On a load with all digits valid, load_err SHALL be 0.
REQ-019 On an up-count, digit 0 SHALL increment.
REQ-020 On an up-count, digit k SHALL increment only when all lower digits are 9, and each 9 that rolls over SHALL become 0.
REQ-021 The whole cascade SHALL resolve within one cycle, with latency 1 edge from enable to the updated count.
REQ-022 On a down-count, digit 0 SHALL decrement.
REQ-023 On a down-count, digit k SHALL decrement only when all lower digits are 0, and each 0 that borrows SHALL become 9.
REQ-024 Up-count at the maximum with WRAP=1: count SHALL become 0 and carry_out SHALL be 1 for that cycle.
REQ-025 Up-count at the maximum with WRAP=0: count SHALL hold and carry_out SHALL be 1 for that cycle.
REQ-026 Down-count at zero with WRAP=1: count SHALL become the maximum and borrow_out SHALL be 1 for that cycle.
REQ-027 Down-count at zero with WRAP=0: count SHALL hold at 0 and borrow_out SHALL be 1 for that cycle.
REQ-028 carry_out, borrow_out and load_err SHALL be 0 on every edge that does not raise them.
REQ-029 No two of carry_out, borrow_out and load_err SHALL ever be 1 in the same cycle.
REQ-030 A direction change while enable is high SHALL take effect on the very next edge, with no dead cycle.
REQ-031 If load_n and enable are both active, the load SHALL win and no count SHALL occur.
REQ-032 With enable low and load_n high, count and all flags SHALL hold, and pulse outputs SHALL be 0.
REQ-033 count SHALL never hold a non-BCD digit after any edge.

Reset
REQ-034 When clear_n is low at a rising edge, count SHALL be 0 and carry_out, borrow_out and load_err SHALL be 0 after that edge.
REQ-035 Reset SHALL override load_n and enable in the same cycle.
REQ-036 Reset asserted mid-count SHALL discard any pending carry or borrow.
REQ-037 Before the first reset edge, outputs SHALL be treated as unknown; the bench SHALL apply reset first.
REQ-038 Immediately after reset, at_zero SHALL be 1 and at_max SHALL be 0.

Verification
REQ-039 Basic up-count (DIGITS=2, WRAP=1): reset, then enable=1, updown=1 for 100 edges -> count steps 00,01..09,10..99,00; carry_out is high only on the 99->00 edge; there are no hex values 0A-0F.
REQ-040 Saturate and borrow (WRAP=0): load 97, count up for 4 edges -> count is 98, 99, 99, 99 and carry_out pulses on edges 3 and 4; then load 01 and count down for 3 edges -> count is 00, 00, 00 and borrow_out pulses on edges 2 and 3.
REQ-041 Down-wrap (WRAP=1): load 10, count down for 2 edges -> count is 09, then 08; then load 00 and count down once -> count is 99 and borrow_out pulses once.
REQ-042 Invalid load: load_data=0xB4 -> count is 94 and load_err is 1 for one cycle; load_data=0x37 -> load_err is 0.
REQ-043 Priority: load 0x55 with load_n=0, enable=1, updown=1 -> count is 55; in the same cycle as a count at 42, drive clear_n=0 with load_n=0 -> count is 00 and all pulse outputs are 0.
REQ-044 Enable and direction: at 50, hold enable low for 3 edges -> count stays 50; then toggle updown every edge with enable=1 -> count is 51, 50, 51, 50.
